// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock first-word-fall-through FIFO.
// Width and depth defaults match the UART <-> Morse byte buffering path.
package sync_fifo_pkg;

   localparam int DEFAULT_WORD_BITS = 8;
   localparam int DEFAULT_ADDR_BITS = 4;

endpackage

// File: rtl/sync_fifo_ptr.sv
// FIFO pointer: ADDR_BITS index bits plus one wrap bit, advanced by an increment enable.
// The wrap bit lets full and empty be told apart when the index bits match.
module sync_fifo_ptr
   import sync_fifo_pkg::*;
#(
   parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               inc_i,
   output logic [ADDR_BITS:0] ptr_o
);

   localparam logic [ADDR_BITS:0] PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

   logic [ADDR_BITS:0] ptr_q;
   logic [ADDR_BITS:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) begin
         ptr_d = ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy, almost flags and
// registered one-cycle overflow/underflow pulses. The memory is deliberately not reset.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WORD_BITS        = DEFAULT_WORD_BITS,
   parameter int ADDR_BITS        = DEFAULT_ADDR_BITS,
   parameter int ALMOST_FULL_LVL  = (1 << ADDR_BITS) - 1,
   parameter int ALMOST_EMPTY_LVL = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rd,
   input  logic                 i_wr,
   input  logic [WORD_BITS-1:0] i_wdata,
   output logic                 o_empty,
   output logic                 o_full,
   output logic [WORD_BITS-1:0] o_rdata,
   output logic [ADDR_BITS:0]   o_count,
   output logic                 o_almost_full,
   output logic                 o_almost_empty,
   output logic                 o_overflow,
   output logic                 o_underflow
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS:0] AF_LVL = ALMOST_FULL_LVL[ADDR_BITS:0];
   localparam logic [ADDR_BITS:0] AE_LVL = ALMOST_EMPTY_LVL[ADDR_BITS:0];

   logic [WORD_BITS-1:0] mem [DEPTH];
   logic [ADDR_BITS:0]   wrPtr;
   logic [ADDR_BITS:0]   rdPtr;
   logic                 isEmpty;
   logic                 isFull;
   logic                 rdAccept;
   logic                 wrAccept;
   logic                 overflow_q;
   logic                 overflow_d;
   logic                 underflow_q;
   logic                 underflow_d;

   assign isEmpty = (wrPtr == rdPtr);
   assign isFull  = (wrPtr[ADDR_BITS-1:0] == rdPtr[ADDR_BITS-1:0]) &&
                    (wrPtr[ADDR_BITS] != rdPtr[ADDR_BITS]);

   // A full FIFO still takes a write when a pop frees the head slot in the same cycle.
   assign rdAccept = i_rd && !isEmpty;
   assign wrAccept = i_wr && (!isFull || rdAccept);

   sync_fifo_ptr #(.ADDR_BITS(ADDR_BITS)) uWrPtr (
      .clk_i  (i_clk),
      .rst_ni (i_reset),
      .inc_i  (wrAccept),
      .ptr_o  (wrPtr)
   );

   sync_fifo_ptr #(.ADDR_BITS(ADDR_BITS)) uRdPtr (
      .clk_i  (i_clk),
      .rst_ni (i_reset),
      .inc_i  (rdAccept),
      .ptr_o  (rdPtr)
   );

   always_ff @(posedge i_clk) begin
      if (wrAccept) begin
         mem[wrPtr[ADDR_BITS-1:0]] <= i_wdata;
      end
   end

   always_comb begin
      overflow_d  = i_wr && isFull && !i_rd;
      underflow_d = i_rd && isEmpty && !i_wr;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign o_empty        = isEmpty;
   assign o_full         = isFull;
   assign o_count        = wrPtr - rdPtr;
   assign o_rdata        = isEmpty ? '0 : mem[rdPtr[ADDR_BITS-1:0]];
   assign o_almost_full  = (o_count >= AF_LVL);
   assign o_almost_empty = (o_count <= AE_LVL);
   assign o_overflow     = overflow_q;
   assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a randomized run
// compared against a queue-based model of the FIFO's behaviour.
module tb_sync_fifo;

   localparam int WB    = 8;
   localparam int AB    = 4;
   localparam int DEPTH = 16;

   logic          i_clk;
   logic          i_reset;
   logic          i_rd;
   logic          i_wr;
   logic [WB-1:0] i_wdata;
   logic          o_empty;
   logic          o_full;
   logic [WB-1:0] o_rdata;
   logic [AB:0]   o_count;
   logic          o_almost_full;
   logic          o_almost_empty;
   logic          o_overflow;
   logic          o_underflow;

   int compared;
   int mismatched;

   logic [WB-1:0] q[$];
   logic          expOv;
   logic          expUn;

   sync_fifo dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_rd           (i_rd),
      .i_wr           (i_wr),
      .i_wdata        (i_wdata),
      .o_empty        (o_empty),
      .o_full         (o_full),
      .o_rdata        (o_rdata),
      .o_count        (o_count),
      .o_almost_full  (o_almost_full),
      .o_almost_empty (o_almost_empty),
      .o_overflow     (o_overflow),
      .o_underflow    (o_underflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // One clock cycle of stimulus; the model applies the acceptance rules to its queue.
   task automatic doCycle(input logic rd, input logic wr, input logic [WB-1:0] data);
      int  size;
      bit  rdOk;
      bit  wrOk;
      i_rd    = rd;
      i_wr    = wr;
      i_wdata = data;
      @(posedge i_clk);
      size  = q.size();
      rdOk  = rd && (size > 0);
      wrOk  = wr && ((size < DEPTH) || rdOk);
      expOv = wr && !wrOk;
      expUn = rd && (size == 0) && !wr;
      if (rdOk) void'(q.pop_front());
      if (wrOk) q.push_back(data);
      #1;
      i_rd = 1'b0;
      i_wr = 1'b0;
   endtask

   task automatic applyReset();
      i_reset = 1'b0;
      @(negedge i_clk);
      i_reset = 1'b1;
      q.delete();
      expOv = 1'b0;
      expUn = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      applyReset();
      compared++;
      if (o_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty got=%b exp=1", o_empty); end
      compared++;
      if (o_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full got=%b exp=0", o_full); end
      compared++;
      if (o_count !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_count got=%0d exp=0", o_count); end
      compared++;
      if (o_rdata !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rdata got=%h exp=00", o_rdata); end
      compared++;
      if (o_almost_empty !== 1'b1 || o_almost_full !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", o_almost_empty, o_almost_full);
      end
      compared++;
      if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset_errs got ov=%b un=%b exp 0 0", o_overflow, o_underflow);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         doCycle(1'b0, 1'b1, 8'(i));
         compared++;
         if (o_count !== 5'(i + 1) || o_rdata !== 8'h00) begin
            mismatched++; $display("[TB] FAIL fill_step%0d got count=%0d rdata=%h exp count=%0d rdata=00", i, o_count, o_rdata, i + 1);
         end
      end
      compared++;
      if (o_full !== 1'b1 || o_empty !== 1'b0 || o_almost_full !== 1'b1) begin
         mismatched++; $display("[TB] FAIL fill_full got full=%b empty=%b af=%b exp 1 0 1", o_full, o_empty, o_almost_full);
      end
      doCycle(1'b0, 1'b1, 8'd16);
      compared++;
      if (o_overflow !== 1'b1 || o_count !== 5'd16 || o_rdata !== 8'h00) begin
         mismatched++; $display("[TB] FAIL fill_overflow got ov=%b count=%0d rdata=%h exp 1 16 00", o_overflow, o_count, o_rdata);
      end
      doCycle(1'b0, 1'b0, 8'h00);
      compared++;
      if (o_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL overflow_once got=%b exp=0", o_overflow); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) begin
         compared++;
         if (o_rdata !== 8'(i)) begin mismatched++; $display("[TB] FAIL drain_data%0d got=%h exp=%h", i, o_rdata, 8'(i)); end
         doCycle(1'b1, 1'b0, 8'h00);
      end
      compared++;
      if (o_empty !== 1'b1 || o_full !== 1'b0 || o_count !== 5'd0) begin
         mismatched++; $display("[TB] FAIL drain_empty got empty=%b full=%b count=%0d exp 1 0 0", o_empty, o_full, o_count);
      end
      doCycle(1'b1, 1'b0, 8'h00);
      compared++;
      if (o_underflow !== 1'b1 || o_rdata !== 8'h00) begin
         mismatched++; $display("[TB] FAIL drain_underflow got un=%b rdata=%h exp 1 00", o_underflow, o_rdata);
      end
      doCycle(1'b0, 1'b0, 8'h00);
      compared++;
      if (o_underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL underflow_once got=%b exp=0", o_underflow); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) doCycle(1'b0, 1'b1, 8'(8'h10 + i));
      for (int i = 0; i < 10; i++) begin
         compared++;
         if (o_rdata !== 8'(8'h10 + i)) begin mismatched++; $display("[TB] FAIL wrap_first%0d got=%h exp=%h", i, o_rdata, 8'(8'h10 + i)); end
         doCycle(1'b1, 1'b0, 8'h00);
      end
      for (int i = 0; i < DEPTH; i++) begin
         doCycle(1'b0, 1'b1, 8'(8'h20 + i));
         compared++;
         if (o_full !== (i == DEPTH - 1)) begin
            mismatched++; $display("[TB] FAIL wrap_full%0d got=%b exp=%b", i, o_full, (i == DEPTH - 1));
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         compared++;
         if (o_rdata !== 8'(8'h20 + i)) begin mismatched++; $display("[TB] FAIL wrap_data%0d got=%h exp=%h", i, o_rdata, 8'(8'h20 + i)); end
         doCycle(1'b1, 1'b0, 8'h00);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < DEPTH; i++) doCycle(1'b0, 1'b1, 8'(8'h30 + i));
      doCycle(1'b1, 1'b1, 8'hAA);
      compared++;
      if (o_count !== 5'd16 || o_full !== 1'b1 || o_overflow !== 1'b0 || o_rdata !== 8'h31) begin
         mismatched++; $display("[TB] FAIL full_rdwr got count=%0d full=%b ov=%b rdata=%h exp 16 1 0 31", o_count, o_full, o_overflow, o_rdata);
      end
      for (int i = 0; i < DEPTH; i++) begin
         compared++;
         if (o_rdata !== ((i == DEPTH - 1) ? 8'hAA : 8'(8'h31 + i))) begin
            mismatched++; $display("[TB] FAIL full_rdwr_drain%0d got=%h exp=%h", i, o_rdata, ((i == DEPTH - 1) ? 8'hAA : 8'(8'h31 + i)));
         end
         doCycle(1'b1, 1'b0, 8'h00);
      end
      doCycle(1'b1, 1'b1, 8'h55);
      compared++;
      if (o_count !== 5'd1 || o_rdata !== 8'h55 || o_underflow !== 1'b0) begin
         mismatched++; $display("[TB] FAIL empty_rdwr got count=%0d rdata=%h un=%b exp 1 55 0", o_count, o_rdata, o_underflow);
      end
      doCycle(1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) doCycle(1'b0, 1'b1, 8'(8'h60 + i));
      #3;
      i_reset = 1'b0;
      #1;
      compared++;
      if (o_empty !== 1'b1 || o_count !== 5'd0 || o_rdata !== 8'h00 || o_full !== 1'b0) begin
         mismatched++; $display("[TB] FAIL midreset got empty=%b count=%0d rdata=%h full=%b exp 1 0 00 0", o_empty, o_count, o_rdata, o_full);
      end
      #1;
      i_reset = 1'b1;
      q.delete();
      doCycle(1'b0, 1'b1, 8'h77);
      compared++;
      if (o_count !== 5'd1 || o_rdata !== 8'h77) begin
         mismatched++; $display("[TB] FAIL midreset_new got count=%0d rdata=%h exp 1 77", o_count, o_rdata);
      end
      doCycle(1'b1, 1'b0, 8'h00);
      compared++;
      if (o_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_drain got empty=%b exp 1", o_empty); end
   endtask

   task automatic test_random();
      logic [WB-1:0] expData;
      applyReset();
      for (int c = 0; c < 400; c++) begin
         doCycle(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)));
         expData = (q.size() > 0) ? q[0] : 8'h00;
         compared++;
         if (o_rdata !== expData) begin mismatched++; $display("[TB] FAIL rnd_rdata c=%0d got=%h exp=%h", c, o_rdata, expData); end
         compared++;
         if (o_count !== 5'(q.size())) begin mismatched++; $display("[TB] FAIL rnd_count c=%0d got=%0d exp=%0d", c, o_count, q.size()); end
         compared++;
         if (o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH)) begin
            mismatched++; $display("[TB] FAIL rnd_status c=%0d got empty=%b full=%b size=%0d", c, o_empty, o_full, q.size());
         end
         compared++;
         if (o_almost_full !== (q.size() >= DEPTH - 1) || o_almost_empty !== (q.size() <= 1)) begin
            mismatched++; $display("[TB] FAIL rnd_almost c=%0d got af=%b ae=%b size=%0d", c, o_almost_full, o_almost_empty, q.size());
         end
         compared++;
         if (o_overflow !== expOv || o_underflow !== expUn) begin
            mismatched++; $display("[TB] FAIL rnd_errs c=%0d got ov=%b un=%b exp ov=%b un=%b", c, o_overflow, o_underflow, expOv, expUn);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      i_reset    = 1'b1;
      i_rd       = 1'b0;
      i_wr       = 1'b0;
      i_wdata    = '0;
      #2;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
